mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 12: address width, which gives a 4096-word memory.
REQ-002 SHALL have parameter DW, default 16: data word width.
REQ-003 SHALL have port CLK, input, 1: clock; all state updates on rising edge.
REQ-004 SHALL have port RESET, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have ports req0/req1, input, 1 each: access request from port 0 (processor) and port 1 (loader/debug).
REQ-006 SHALL have ports we0/we1, input, 1 each: 1 = write, 0 = read.
REQ-007 SHALL have ports addr0/addr1, input, AW each: word address.
REQ-008 SHALL have ports wdata0/wdata1, input, DW each: write data.
REQ-009 SHALL have ports gnt0/gnt1, output, 1 each: registered one-cycle grant pulse.
REQ-010 SHALL have ports rvalid0/rvalid1, output, 1 each: registered one-cycle read-data-valid pulse.
REQ-011 SHALL have ports rdata0/rdata1, output, DW each: read data, valid while the matching rvalid is 1.
REQ-012 SHALL have port mem_en, output, 1: memory access strobe.
REQ-013 SHALL have port mem_we, output, 1: memory write enable, qualified by mem_en.
REQ-014 SHALL have port mem_addr, output, AW: memory address.
REQ-015 SHALL have port mem_wdata, output, DW: memory write data.
REQ-016 SHALL have port mem_rdata, input, DW: synchronous-read memory data, valid the cycle after the mem_en read cycle.
REQ-017 SHALL have port busy, output, 1: 1 whenever the FSM is not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, RDWAIT.
REQ-019 In IDLE with req0|req1 at an edge, SHALL latch the winner's we/addr/wdata and the winner ID, and go to ISSUE.
REQ-020 In IDLE with no request at an edge, SHALL stay in IDLE.
REQ-021 In ISSUE, SHALL drive gnt of the winner and mem_en to 1, with mem_we/mem_addr/mem_wdata taken from the latched command.
REQ-022 ISSUE SHALL go to IDLE for a write and to RDWAIT for a read.
REQ-023 RDWAIT SHALL capture mem_rdata into the winner's rdata, pulse that port's rvalid in the next cycle, and go to IDLE.
REQ-024 Latency with req sampled at edge N: gnt and mem_en high in cycle N+1; for reads, rvalid high in cycle N+3.
REQ-025 Throughput SHALL be one write per 2 cycles and one read per 3 cycles.
REQ-026 Requesters SHALL hold req/we/addr/wdata stable until gnt is sampled, and SHALL drop req the cycle after gnt unless issuing a new request.
REQ-027 Requests arriving while busy SHALL be ignored until IDLE; no queuing.
REQ-028 A request present in the IDLE cycle in which rvalid fires SHALL be accepted normally.
REQ-029 gnt0 and gnt1 SHALL never be 1 in the same cycle, and rvalid SHALL go only to the port whose read was granted.
REQ-030 rdata0/rdata1 SHALL hold their last captured value between reads.
REQ-031 mem_en SHALL be 0 in IDLE and RDWAIT, and mem_we SHALL be 0 whenever mem_en is 0.

Reset
REQ-032 RESET sampled high SHALL force IDLE at that edge, and SHALL clear gnt0/1, rvalid0/1, mem_en, mem_we, busy, mem_addr, mem_wdata, rdata0/1 and the latched command to 0.
REQ-033 RESET during ISSUE or RDWAIT SHALL abort the access; no rvalid is produced for the aborted read.
REQ-034 RESET SHALL set last_winner to 1, so port 0 wins the first contested arbitration.

Configuration
REQ-035 The feature macro SHALL be MEM_PORT_ARBITER_RR_EN.
REQ-036 With MEM_PORT_ARBITER_RR_EN defined, contested arbitration in IDLE SHALL grant the port not in last_winner, and last_winner SHALL update on every grant.
REQ-037 Without MEM_PORT_ARBITER_RR_EN, port 0 SHALL always win contested arbitration; port 1 may starve, and last_winner logic SHALL be omitted.
REQ-038 Uncontested arbitration SHALL grant the sole requester in both builds.

Verification
REQ-039 Port 0 write addr 0x014 data 0x3000 -> gnt0 and mem_en/mem_we in the next cycle, mem_addr=0x014, mem_wdata=0x3000, back to IDLE after 2 cycles.
REQ-040 Port 1 read addr 0x007 with mem_rdata=0xA5A5 -> gnt1 in N+1, rvalid1=1 and rdata1=0xA5A5 in N+3, rvalid0 stays 0.
REQ-041 req0 and req1 (both reads) held high continuously -> RR build grants 0,1,0,1; fixed build grants 0,0,0 and never gnt1.
REQ-042 RESET asserted during RDWAIT of a port 0 read -> next cycle IDLE, all outputs 0, no rvalid0.
REQ-043 A new req0 presented in the rvalid0 cycle -> accepted with gnt0 in the following cycle, giving back-to-back reads every 3 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port arbiter in front of a single-port synchronous-read memory
//
// Purpose:
//   Two requesters (port 0 = processor, port 1 = loader/debug) share one
//   single-port memory. One access is in flight at a time; requests seen
//   while busy are ignored (no queuing).
//   Sequence: IDLE -> ISSUE -> IDLE for writes (one write per 2 cycles),
//   IDLE -> ISSUE -> RDWAIT -> IDLE for reads (one read per 3 cycles).
//
// Build option:
//   MEM_PORT_ARBITER_RR_EN  defined   : contested requests alternate (round robin)
//                           undefined : port 0 always wins a contest
//
// Ports:
//   CLK, RESET               clock, synchronous active-high reset
//   req0/req1                access request per port
//   we0/we1                  1 = write, 0 = read
//   addr0/addr1 [AW]         word address per port
//   wdata0/wdata1 [DW]       write data per port
//   gnt0/gnt1                one-cycle grant pulse (the ISSUE cycle)
//   rvalid0/rvalid1          one-cycle read-data-valid pulse
//   rdata0/rdata1 [DW]       read data, held until the next read of that port
//   mem_en, mem_we           memory strobe and write enable
//   mem_addr, mem_wdata      memory address / write data
//   mem_rdata [DW]           memory read data, valid the cycle after the read strobe
//   busy                     1 whenever the FSM is not IDLE

module mem_port_arbiter #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t        r_state;

  // Latched command of the current winner
  logic          r_cmd_we;
  logic          r_cmd_id;
  logic [AW-1:0] r_cmd_addr;
  logic [DW-1:0] r_cmd_wdata;

  // Registered outputs
  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_rvalid0;
  logic          r_rvalid1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic          r_mem_en;
  logic          r_mem_we;
  logic          r_busy;

  logic          w_any_req;
  logic          w_pick1;
  logic          w_win_we;
  logic [AW-1:0] w_win_addr;
  logic [DW-1:0] w_win_wdata;

  assign w_any_req = req0 | req1;

`ifdef MEM_PORT_ARBITER_RR_EN
  logic r_last_winner;

  // Sole requester always wins; on a contest the port that did not win
  // last time goes next.
  assign w_pick1 = req1 & (~req0 | ~r_last_winner);
`else
  // Fixed priority: port 1 only wins when port 0 is not asking.
  assign w_pick1 = req1 & ~req0;
`endif

  assign w_win_we    = w_pick1 ? we1    : we0;
  assign w_win_addr  = w_pick1 ? addr1  : addr0;
  assign w_win_wdata = w_pick1 ? wdata1 : wdata0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_cmd_we    <= 1'b0;
      r_cmd_id    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_busy      <= 1'b0;
`ifdef MEM_PORT_ARBITER_RR_EN
      r_last_winner <= 1'b1;
`endif
    end else begin
      // Pulsed outputs default low; each state raises what it owns.
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_mem_en  <= 1'b0;
      r_mem_we  <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_cmd_we    <= w_win_we;
            r_cmd_id    <= w_pick1;
            r_cmd_addr  <= w_win_addr;
            r_cmd_wdata <= w_win_wdata;
            // Grant and strobe are raised here so they are high during ISSUE.
            r_gnt0      <= ~w_pick1;
            r_gnt1      <= w_pick1;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_win_we;
            r_busy      <= 1'b1;
            r_state     <= ISSUE;
`ifdef MEM_PORT_ARBITER_RR_EN
            r_last_winner <= w_pick1;
`endif
          end
        end

        ISSUE: begin
          if (r_cmd_we) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_state <= RDWAIT;
          end
        end

        RDWAIT: begin
          // mem_rdata is valid now (one cycle after the read strobe).
          if (r_cmd_id) begin
            r_rdata1  <= mem_rdata;
            r_rvalid1 <= 1'b1;
          end else begin
            r_rdata0  <= mem_rdata;
            r_rvalid0 <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign rvalid0   = r_rvalid0;
  assign rvalid1   = r_rvalid1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  // Address/data come straight from the latched command; qualified by mem_en.
  assign mem_addr  = r_cmd_addr;
  assign mem_wdata = r_cmd_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter

module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req0, req1, we0, we1;
  logic [11:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  mem_port_arbiter #(.AW(12), .DW(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Memory seen by the DUT
  logic [15:0] tbmem [0:4095];
  always @(posedge CLK) begin
    if (mem_en && mem_we)  tbmem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= tbmem[mem_addr];
  end

  // Reference model: transaction-level scheduling with a shadow memory.
  typedef struct {
    int          iv;     // interval (index of the edge it follows)
    bit          kind;   // 0 = grant/issue, 1 = read return
    bit          port;
    bit          we;
    logic [11:0] addr;
    logic [15:0] data;
  } ev_t;

  typedef struct {
    bit port;
    int iv;
  } glog_t;

  ev_t         sb[$];
  glog_t       gnt_log[$];
  logic [15:0] shadow [0:4095];
  int          edge_cnt  = 0;
  int          free_edge = 0;
  int          busy_lo   = 1;
  int          busy_hi   = 0;
  bit          last_w    = 1'b1;
  bit          rst_edge  = 1'b0;
  logic [15:0] exp_rd0   = '0;
  logic [15:0] exp_rd1   = '0;
  bit          m_p;
  bit          m_we;
  logic [11:0] m_a;
  logic [15:0] m_d;

  always @(posedge CLK) begin
    edge_cnt++;
    rst_edge = RESET;
    if (RESET) begin
      sb.delete();
      free_edge = edge_cnt + 1;
      busy_lo   = 1;
      busy_hi   = 0;
      last_w    = 1'b1;
      exp_rd0   = '0;
      exp_rd1   = '0;
    end else if (edge_cnt >= free_edge && (req0 || req1)) begin
`ifdef MEM_PORT_ARBITER_RR_EN
      m_p = (req0 && req1) ? !last_w : req1;
`else
      m_p = !req0;
`endif
      last_w = m_p;
      m_we = m_p ? we1 : we0;
      m_a  = m_p ? addr1 : addr0;
      m_d  = m_p ? wdata1 : wdata0;
      sb.push_back('{edge_cnt, 1'b0, m_p, m_we, m_a, m_d});
      busy_lo = edge_cnt;
      if (m_we) begin
        shadow[m_a] = m_d;
        free_edge = edge_cnt + 2;
        busy_hi   = edge_cnt;
      end else begin
        sb.push_back('{edge_cnt + 2, 1'b1, m_p, 1'b0, m_a, shadow[m_a]});
        free_edge = edge_cnt + 3;
        busy_hi   = edge_cnt + 1;
      end
    end
  end

  // Monitor: compares every DUT output once per cycle on the falling edge.
  bit          e_g0, e_g1, e_en, e_we, e_rv0, e_rv1;
  logic [11:0] e_a;
  logic [15:0] e_d;
  ev_t         ev;

  always @(negedge CLK) begin
    if (edge_cnt > 0) begin
      e_g0 = 0; e_g1 = 0; e_en = 0; e_we = 0; e_rv0 = 0; e_rv1 = 0;
      e_a = '0; e_d = '0;
      while (sb.size() > 0 && sb[0].iv <= edge_cnt) begin
        ev = sb.pop_front();
        if (ev.iv < edge_cnt) chk("sb_late_event", 32'(ev.iv), 32'(edge_cnt));
        if (!ev.kind) begin
          if (ev.port) e_g1 = 1; else e_g0 = 1;
          e_en = 1; e_we = ev.we; e_a = ev.addr; e_d = ev.data;
        end else if (ev.port) begin
          e_rv1 = 1; exp_rd1 = ev.data;
        end else begin
          e_rv0 = 1; exp_rd0 = ev.data;
        end
      end
      if (gnt0 === 1'b1) gnt_log.push_back('{1'b0, edge_cnt});
      if (gnt1 === 1'b1) gnt_log.push_back('{1'b1, edge_cnt});
      chk("gnt0",    32'(gnt0),    32'(e_g0));
      chk("gnt1",    32'(gnt1),    32'(e_g1));
      chk("mem_en",  32'(mem_en),  32'(e_en));
      chk("mem_we",  32'(mem_we),  32'(e_we));
      chk("rvalid0", 32'(rvalid0), 32'(e_rv0));
      chk("rvalid1", 32'(rvalid1), 32'(e_rv1));
      chk("rdata0",  32'(rdata0),  32'(exp_rd0));
      chk("rdata1",  32'(rdata1),  32'(exp_rd1));
      chk("busy",    32'(busy),    32'(edge_cnt >= busy_lo && edge_cnt <= busy_hi));
      if (e_en) begin
        chk("mem_addr",  32'(mem_addr),  32'(e_a));
        chk("mem_wdata", 32'(mem_wdata), 32'(e_d));
      end
      if (rst_edge) begin
        chk("rst_mem_addr",  32'(mem_addr),  32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
      end
    end
  end

  // Requester helpers (called right after a falling edge)
  task automatic set_req(input bit p, input bit r, input bit w, input logic [11:0] a, input logic [15:0] d);
    if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
  endtask

  task automatic drop(input bit p);
    if (p) req1 = 1'b0; else req0 = 1'b0;
  endtask

  // Present a request and hold it until the grant is seen; returns in the grant cycle.
  task automatic do_req(input bit p, input bit w, input logic [11:0] a, input logic [15:0] d);
    int n;
    bit seen;
    set_req(p, 1'b1, w, a, d);
    seen = 0;
    for (n = 0; n < 300 && !seen; n++) begin
      @(negedge CLK);
      seen = p ? gnt1 : gnt0;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL grant_timeout port=%0d actual=no_grant required=grant", p);
    end
  endtask

  task automatic port_loop(input bit p, input int cnt);
    int gap;
    for (int k = 0; k < cnt; k++) begin
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        drop(p);
        repeat (gap) @(negedge CLK);
      end
      do_req(p, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 31)), 16'($urandom));
    end
    drop(p);
  endtask

  bit exp_order [4];

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      tbmem[i]  = 16'((i * 40503) ^ 23130);
      shadow[i] = 16'((i * 40503) ^ 23130);
    end
    tbmem[7]  = 16'hA5A5;
    shadow[7] = 16'hA5A5;
    RESET = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(negedge CLK);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_rdata0", 32'(rdata0), 32'h0);
    RESET = 1'b0;
    @(negedge CLK);

    // Port 0 write 0x014 <- 0x3000; idle again the cycle after the grant
    do_req(1'b0, 1'b1, 12'h014, 16'h3000);
    drop(1'b0);
    chk("wr_mem_addr",  32'(mem_addr),  32'h014);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'h3000);
    chk("wr_mem_we",    32'(mem_we),    32'h1);
    @(negedge CLK);
    chk("wr_back_idle", 32'(busy), 32'h0);
    repeat (2) @(negedge CLK);

    // Port 1 read 0x007 -> 0xA5A5 two cycles after the grant
    do_req(1'b1, 1'b0, 12'h007, 16'h0);
    drop(1'b1);
    repeat (2) @(negedge CLK);
    chk("rd1_rvalid1", 32'(rvalid1), 32'h1);
    chk("rd1_rdata1",  32'(rdata1),  32'hA5A5);
    chk("rd1_rvalid0", 32'(rvalid0), 32'h0);
    repeat (2) @(negedge CLK);

    // Contested reads held high after a reset
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    gnt_log.delete();
    set_req(1'b0, 1'b1, 1'b0, 12'h003, 16'h0);
    set_req(1'b1, 1'b1, 1'b0, 12'h009, 16'h0);
    repeat (14) @(negedge CLK);
    drop(1'b0);
    drop(1'b1);
    repeat (4) @(negedge CLK);
`ifdef MEM_PORT_ARBITER_RR_EN
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    chk("contest_grants", 32'(gnt_log.size() >= 4), 32'h1);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++)
      chk($sformatf("contest_order%0d", i), 32'(gnt_log[i].port), 32'(exp_order[i]));

    // Reset during RDWAIT of a port 0 read
    do_req(1'b0, 1'b0, 12'h005, 16'h0);
    drop(1'b0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("abort_rvalid0", 32'(rvalid0), 32'h0);
    chk("abort_busy",    32'(busy),    32'h0);
    chk("abort_mem_en",  32'(mem_en),  32'h0);
    chk("abort_rdata0",  32'(rdata0),  32'h0);
    repeat (2) @(negedge CLK);

    // Back-to-back port 0 reads, next request presented immediately
    gnt_log.delete();
    do_req(1'b0, 1'b0, 12'h001, 16'h0);
    do_req(1'b0, 1'b0, 12'h002, 16'h0);
    do_req(1'b0, 1'b0, 12'h014, 16'h0);
    drop(1'b0);
    repeat (4) @(negedge CLK);
    chk("b2b_count", 32'(gnt_log.size()), 32'h3);
    if (gnt_log.size() == 3) begin
      chk("b2b_gap1", 32'(gnt_log[1].iv - gnt_log[0].iv), 32'h3);
      chk("b2b_gap2", 32'(gnt_log[2].iv - gnt_log[1].iv), 32'h3);
    end

    // Randomized traffic from both ports
    fork
      port_loop(1'b0, 40);
      port_loop(1'b1, 40);
    join
    repeat (6) @(negedge CLK);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
